// File: rtl/pipelined_stallable_multiplier.sv
// Pipelined W x W multiplier with signed/unsigned mode, valid/ready on both sides,
// a sideband tag and synchronous flush; each stage retires W/D bits of operand B.
`timescale 1ns/1ps
module pipelined_stallable_multiplier #(
   parameter int DATA_WIDTH     = 16,
   parameter int PIPELINE_DEPTH = 4,
   parameter int TAG_WIDTH      = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      flush_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [DATA_WIDTH-1:0]     operand_A_i,
   input  logic [DATA_WIDTH-1:0]     operand_B_i,
   input  logic                      is_signed_i,
   input  logic [TAG_WIDTH-1:0]      tag_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [2*DATA_WIDTH-1:0]   result_o,
   output logic [TAG_WIDTH-1:0]      tag_o
);

   localparam int W     = DATA_WIDTH;
   localparam int D     = PIPELINE_DEPTH;
   localparam int D_SAFE = (D < 1) ? 1 : D;
   localparam int P     = (D >= 1 && D <= W) ? W / D_SAFE : 1;
   localparam logic [W-1:0]   ONE_W  = W'(1);
   localparam logic [2*W-1:0] ONE_2W = (2*W)'(1);

   if (D < 1 || D > W || (W % D_SAFE) != 0) begin : g_bad_depth
      $error("PIPELINE_DEPTH must satisfy 1 <= D <= DATA_WIDTH and DATA_WIDTH %% D == 0");
   end

   logic                 w_stall;
   logic                 w_vld [0:D];
   logic [TAG_WIDTH-1:0] w_tag [0:D];
   logic [W-1:0]         w_hi  [0:D];
   logic [W-1:0]         w_lo  [0:D];
   logic [W-1:0]         w_a   [0:D-1];
   logic [W-1:0]         w_b   [0:D-1];
   logic                 w_neg [0:D-1];

   assign w_stall  = w_vld[D] && !ready_i;
   assign ready_o  = !w_stall;

   assign w_vld[0] = valid_i && !w_stall;
   assign w_tag[0] = tag_i;
   assign w_hi[0]  = '0;
   assign w_lo[0]  = '0;
   // Magnitudes: -2^(W-1) negates to itself, which is the correct unsigned magnitude.
   assign w_a[0]   = (is_signed_i && operand_A_i[W-1]) ? (~operand_A_i + ONE_W) : operand_A_i;
   assign w_b[0]   = (is_signed_i && operand_B_i[W-1]) ? (~operand_B_i + ONE_W) : operand_B_i;
   assign w_neg[0] = is_signed_i && (operand_A_i[W-1] ^ operand_B_i[W-1]);

   for (genvar k = 0; k < D; k++) begin : g_stage
      logic [W+P-1:0]       w_pp;
      logic [W+P-1:0]       w_sum;
      logic [W-1:0]         w_lo_n;
      logic [W-1:0]         w_hi_d;
      logic [W-1:0]         w_lo_d;
      logic                 r_vld;
      logic [TAG_WIDTH-1:0] r_tag;
      logic [W-1:0]         r_hi;
      logic [W-1:0]         r_lo;

      // hi holds the running sum shifted down by k*P; the add never overflows W+P bits.
      assign w_pp  = {{P{1'b0}}, w_a[k]} * {{W{1'b0}}, w_b[k][k*P +: P]};
      assign w_sum = {{P{1'b0}}, w_hi[k]} + w_pp;

      always_comb begin
         w_lo_n = w_lo[k];
         w_lo_n[k*P +: P] = w_sum[P-1:0];
      end

      if (k == D-1) begin : g_last
         logic [2*W-1:0] w_prod;
         logic [2*W-1:0] w_fin;
         assign w_prod = {w_sum[W+P-1:P], w_lo_n};
         assign w_fin  = w_neg[k] ? (~w_prod + ONE_2W) : w_prod;
         assign w_hi_d = w_fin[2*W-1:W];
         assign w_lo_d = w_fin[W-1:0];
      end else begin : g_mid
         logic [W-1:0] r_a;
         logic [W-1:0] r_b;
         logic         r_neg;
         assign w_hi_d = w_sum[W+P-1:P];
         assign w_lo_d = w_lo_n;

         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               r_a   <= '0;
               r_b   <= '0;
               r_neg <= 1'b0;
            end else if (!flush_i && !w_stall) begin
               r_a   <= w_a[k];
               r_b   <= w_b[k];
               r_neg <= w_neg[k];
            end
         end

         assign w_a[k+1]   = r_a;
         assign w_b[k+1]   = r_b;
         assign w_neg[k+1] = r_neg;
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            r_vld <= 1'b0;
            r_tag <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
         end else if (flush_i) begin
            r_vld <= 1'b0;
         end else if (!w_stall) begin
            r_vld <= w_vld[k];
            r_tag <= w_tag[k];
            r_hi  <= w_hi_d;
            r_lo  <= w_lo_d;
         end
      end

      assign w_vld[k+1] = r_vld;
      assign w_tag[k+1] = r_tag;
      assign w_hi[k+1]  = r_hi;
      assign w_lo[k+1]  = r_lo;
   end

   assign valid_o  = w_vld[D];
   assign tag_o    = w_tag[D];
   assign result_o = {w_hi[D], w_lo[D]};

endmodule

// File: tb/tb_pipelined_stallable_multiplier.sv
// Scoreboard bench: four instances (D = 4, 1, 2, 16) share one stimulus stream;
// the D=4 instance also carries the latency, back-pressure, flush and reset checks.
`timescale 1ns/1ps
module tb_pipelined_stallable_multiplier;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  tag;
   } exp_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic [31:0] e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        vin;
   logic        sgn;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  tin;
   logic        rdy [4];
   logic        ro  [4];
   logic        vo  [4];
   logic [31:0] res [4];
   logic [3:0]  tg  [4];

   exp_t sb [4][$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int DG = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 16;
      pipelined_stallable_multiplier #(
         .DATA_WIDTH(16), .PIPELINE_DEPTH(DG), .TAG_WIDTH(4)
      ) u_dut (
         .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .valid_i(vin), .ready_o(ro[g]),
         .operand_A_i(a), .operand_B_i(b), .is_signed_i(sgn), .tag_i(tin),
         .valid_o(vo[g]), .ready_i(rdy[g]), .result_o(res[g]), .tag_o(tg[g])
      );
   end

   function automatic logic [31:0] ref_mul(logic [15:0] x, logic [15:0] y, logic s);
      longint lx, ly;
      if (s) begin
         lx = longint'($signed(x));
         ly = longint'($signed(y));
      end else begin
         lx = longint'(x);
         ly = longint'(y);
      end
      return 32'(lx * ly);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic monitor_step();
      for (int i = 0; i < 4; i++) begin
         if (!rst_n || flush) begin
            sb[i].delete();
         end else if (vo[i]) begin
            if (sb[i].size() == 0) begin
               check($sformatf("unexpected_valid_inst%0d", i), 32'(vo[i]), 32'd0);
            end else begin
               check($sformatf("result_inst%0d", i), res[i], sb[i][0].res);
               check($sformatf("tag_inst%0d", i), 32'(tg[i]), 32'(sb[i][0].tag));
               if (rdy[i]) void'(sb[i].pop_front());
            end
         end
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the D=4 instance accepted.
   task automatic op(logic [15:0] xa, logic [15:0] xb, logic xs, logic [3:0] xt, logic [31:0] e);
      exp_t ent;
      int   waited;
      bit   done;
      ent.res = e;
      ent.tag = xt;
      a = xa; b = xb; sgn = xs; tin = xt; vin = 1'b1;
      waited = 0;
      done   = 1'b0;
      while (!done) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++)
            if (ro[i] && rst_n && !flush) sb[i].push_back(ent);
         if (ro[0]) done = 1'b1;
         else if (++waited > 200) begin
            check("accept_timeout", 32'(ro[0]), 32'd1);
            done = 1'b1;
         end
      end
      @(posedge clk); #1;
      vin = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++)
         check($sformatf("drain_inst%0d", i), 32'(sb[i].size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t vecs [6] = '{
         '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001},
         '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001},
         '{16'h8000, 16'h8000, 1'b1, 32'h40000000},
         '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1},
         '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000},
         '{16'h8000, 16'h0001, 1'b0, 32'h00008000}
      };
      logic [15:0] ra, rb;
      logic        rs;
      int          n;

      rst_n = 1'b0; flush = 1'b0; vin = 1'b0; sgn = 1'b0; a = '0; b = '0; tin = '0;
      for (int i = 0; i < 4; i++) rdy[i] = 1'b1;

      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
      join_none

      #12;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reset_valid_inst%0d", i), 32'(vo[i]), 32'd0);
         check($sformatf("reset_result_inst%0d", i), res[i], 32'd0);
         check($sformatf("reset_tag_inst%0d", i), 32'(tg[i]), 32'd0);
         check($sformatf("reset_ready_inst%0d", i), 32'(ro[i]), 32'd1);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: valid_o rises right after the 4th edge counting the accept edge.
      op(16'hFFFF, 16'hFFFF, 1'b0, 4'h1, 32'hFFFE0001);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         check($sformatf("latency_edge%0d", k + 1), 32'(vo[0]), (k == 3) ? 32'd1 : 32'd0);
      end
      drain();

      for (int k = 0; k < 6; k++) op(vecs[k].a, vecs[k].b, vecs[k].s, 4'(k), vecs[k].e);
      drain();

      // Streaming: 8 back-to-back ops; results must be back-to-back too.
      for (int t = 0; t < 8; t++) begin
         ra = 16'(t * 4663 + 7);
         rb = 16'(16'hF00D - t * 999);
         rs = t[0];
         op(ra, rb, rs, 4'(t), ref_mul(ra, rb, rs));
      end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         check($sformatf("stream_valid_%0d", k), 32'(vo[0]), (k < 4) ? 32'd1 : 32'd0);
      end
      drain();

      // Back-pressure: hold ready_i low for 3 cycles while results are waiting.
      fork
         begin
            for (int t = 0; t < 6; t++) begin
               ra = 16'(16'h1234 * (t + 1));
               rb = 16'(16'hFEDC - 16'h0321 * t);
               op(ra, rb, t[1], 4'(8 + t), ref_mul(ra, rb, t[1]));
            end
         end
         begin
            n = 0;
            while (!vo[0] && n < 50) begin
               @(posedge clk); #1;
               n++;
            end
            check("bp_wait_valid", 32'(vo[0]), 32'd1);
            rdy[0] = 1'b0;
            for (int k = 0; k < 3; k++) begin
               #1;
               check($sformatf("bp_ready_low_%0d", k), 32'(ro[0]), 32'd0);
               @(posedge clk); #1;
            end
            rdy[0] = 1'b1;
         end
      join
      drain();

      // Flush with three operations in flight and a new offer in the flush cycle.
      op(16'h0003, 16'h0004, 1'b0, 4'h1, 32'h0000000C);
      op(16'h0005, 16'h0006, 1'b0, 4'h2, 32'h0000001E);
      op(16'h0007, 16'h0008, 1'b0, 4'h3, 32'h00000038);
      flush = 1'b1; vin = 1'b1; a = 16'h0009; b = 16'h0009; tin = 4'hF;
      @(posedge clk); #1;
      flush = 1'b0; vin = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("flush_quiet_%0d", k), 32'(vo[0]), 32'd0);
         @(posedge clk); #1;
      end
      op(16'hFFFE, 16'h0003, 1'b1, 4'hA, 32'hFFFFFFFA);
      drain();

      // Reset while the D=4 pipeline is full and stalled.
      rdy[0] = 1'b0;
      op(16'h0011, 16'h0011, 1'b0, 4'h4, 32'h00000121);
      op(16'h0012, 16'h0012, 1'b0, 4'h5, 32'h00000144);
      op(16'h0013, 16'h0013, 1'b0, 4'h6, 32'h00000169);
      op(16'h0014, 16'h0014, 1'b0, 4'h7, 32'h00000190);
      check("stall_before_reset", 32'(ro[0]), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(vo[0]), 32'd0);
      check("rst_mid_result", res[0], 32'd0);
      check("rst_mid_tag", 32'(tg[0]), 32'd0);
      check("rst_mid_ready", 32'(ro[0]), 32'd1);
      @(posedge clk); #1;
      rst_n  = 1'b1;
      rdy[0] = 1'b1;
      @(posedge clk); #1;

      for (int t = 0; t < 40; t++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (t % 10 == 0) ra = 16'h8000;
         rs = 1'($urandom_range(0, 1));
         op(ra, rb, rs, 4'(t), ref_mul(ra, rb, rs));
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
